dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Data-side memory responder for the 5-stage core: services MEM-stage loads/stores (address, write data,
//   write enable, byte enables) and returns a full read word the same cycle; the core's load extender picks lanes.
//   Maps a word RAM, a console TX FIFO drained by a valid/ready sink, a status reg and a free-running 64-bit cycle counter.
// PARAMETERS
//   RAM_WORDS   1024          RAM depth in 32-bit words (power of 2); RAM occupies 0x0 .. RAM_WORDS*4-1
//   IO_BASE     32'h1000_0000 base of I/O window (word-aligned, outside RAM)
//   FIFO_DEPTH  4             console FIFO entries (power of 2, >=2)
//   INIT_FILE   ""            $readmemh image for RAM at elaboration; "" = no preload
// PORTS
//   clk            in   1   clock; all state updates on rising edge
//   clr            in   1   asynchronous reset, active-high
//   addr           in   32  byte address (core ALUResultM)
//   wdata          in   32  store data, unshifted, low-order justified (core WriteDataM)
//   we             in   1   store strobe (core MemWriteM)
//   byte_en        in   4   lane enables from core: 0001/0010/0100/1000 sb, 0011/1100 sh, 1111 sw
//   rdata          out  32  combinational read word (core RD_data)
//   console_data   out  8   FIFO head byte
//   console_valid  out  1   FIFO non-empty
//   console_ready  in   1   sink accepts head when valid&ready
//   overflow       out  1   sticky: console push dropped because FIFO full
// BEHAVIOUR
//   Reads: combinational, side-effect free, word-granular (addr[1:0] ignored). RAM -> mem[addr[.:2]];
//     IO_BASE+0x0 -> 0; +0x4 STATUS -> {23'b0, overflow, 4'b0, count[3:0]} (count = FIFO occupancy);
//     +0x8 CYCLE_LO -> cycle[31:0]; +0xC CYCLE_HI -> cycle[63:32]; unmapped -> 32'h0.
//   RAM writes (we=1, addr in RAM): lane steering by responder, committed at clock edge, visible to reads next cycle:
//     one-hot byte_en -> wdata[7:0] into enabled lane; 0011 -> wdata[15:0] to lanes 1:0; 1100 -> wdata[15:0] to 3:2;
//     1111 -> wdata to whole word; any other byte_en (incl. 0000) -> no write. Untouched lanes keep their value.
//   Console (we=1, addr=IO_BASE+0x0, byte_en!=0): push wdata[7:0]. Pop on console_valid&console_ready.
//     Push when full and no pop same cycle -> dropped, overflow<=1. Push+pop same cycle when full -> both
//     happen, count unchanged. Push+pop when empty -> push only (valid low, nothing to pop). FIFO order strict.
//     console_data/console_valid stable while valid&!ready.
//   STATUS write (we=1, +0x4, byte_en[1]=1, wdata[8]=1) clears overflow; a same-cycle overflow set wins.
//   Cycle counter: +1 every cycle, wraps 2^64-1 -> 0; writes to +0x8/+0xC ignored. Software reads HI/LO/HI.
//   Writes to unmapped or read-only addresses: ignored, no side effects.
//   Reset (clr=1, async): FIFO empty (console_valid=0, console_data=8'h00), count=0, overflow=0, cycle=0.
//     RAM contents NOT cleared by clr. Reset mid-stream discards queued bytes; in-flight store that cycle lost.
//   Latency: read 0 cycles; store -> RAM/FIFO/flag update at the next edge; push -> console_valid next cycle.
// CONFIGURATION
//   TOHOST_EN defined: adds ports halt (out,1) and tohost_value (out,32); address IO_BASE+0x10.
//     sw (byte_en=1111) there while halt=0 -> halt<=1, tohost_value<=wdata; later stores ignored until clr.
//     Cycle counter freezes while halt=1. Read of +0x10 returns tohost_value. Reset: halt=0, tohost_value=0.
//   TOHOST_EN undefined: ports absent, +0x10 unmapped (reads 0, writes ignored), counter never freezes.
// TESTING
//   T1 sw 0xDEADBEEF @0x100, then sb 0xAA (wdata=0x000000AA, byte_en=0100) @0x102 -> read @0x100 = 0xDEAABEEF.
//   T2 sh 0x1234 (byte_en=1100) @0x202 over 0 -> read 0x12340000; byte_en=0101 store -> word unchanged.
//   T3 console_ready=0, push 'A','B','C','D','E' -> STATUS=0x00000104, console_data='A'; ready=1 -> 'A'..'D'
//      drain in order one per cycle, then console_valid=0; STATUS write 0x100 -> overflow=0.
//   T4 FIFO full, ready=1, push 'Z' same cycle -> 'A' popped, 'Z' queued, count stays 4, overflow stays 0.
//   T5 after clr release, read CYCLE_LO on cycle N -> N; force counter to 0x00000000_FFFFFFFF -> next cycle
//      HI=1, LO=0; writes to +0x8 leave counter unchanged.
//   T6 (TOHOST_EN) sw 0x1 @IO_BASE+0x10 -> halt=1, tohost_value=1 next cycle; CYCLE_LO constant thereafter;
//      second sw 0x5 -> tohost_value stays 1; clr mid-halt -> halt=0, RAM data from T1 preserved.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data responder -- word RAM, console TX FIFO, status reg, 64-bit cycle counter.
// Optional build macro TOHOST_EN adds halt/tohost_value and a tohost register at IO_BASE+0x10.
module dmem_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] IO_BASE    = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
`ifdef TOHOST_EN
  output logic        halt,
  output logic [31:0] tohost_value,
`endif
  output logic        overflow
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam logic [2:0] R_CON = 3'd0, R_STAT = 3'd1, R_CLO = 3'd2, R_CHI = 3'd3;
`ifdef TOHOST_EN
  localparam logic [2:0] R_HOST = 3'd4;
`endif

  logic [31:0] mem [RAM_WORDS];

  // Word-granular decode; the I/O window is eight words starting at IO_BASE.
  logic              ram_hit, io_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [29:0]       io_woff;
  logic [2:0]        io_reg;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];
  assign ram_hit = (addr[31:RAM_AW+2] == '0);
  assign ram_idx = addr[RAM_AW+1:2];
  assign io_woff = addr[31:2] - IO_BASE[31:2];
  assign io_hit  = (io_woff[29:3] == '0);
  assign io_reg  = io_woff[2:0];

  // Store lane steering: only the legal sb/sh/sw enable patterns write.
  logic [3:0]  wmask;
  logic [31:0] wlanes;
  logic        ram_we;

  always_comb begin
    wmask  = 4'b0000;
    wlanes = wdata;
    case (byte_en)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        wmask  = byte_en;
        wlanes = {4{wdata[7:0]}};
      end
      4'b0011, 4'b1100: begin
        wmask  = byte_en;
        wlanes = {2{wdata[15:0]}};
      end
      4'b1111: begin
        wmask  = 4'b1111;
        wlanes = wdata;
      end
      default: wmask = 4'b0000;
    endcase
  end

  assign ram_we = we & ram_hit & ~clr;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[ram_idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  // Console FIFO
  logic [7:0]     fifo_q [FIFO_DEPTH];
  logic [FAW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [FAW:0]   cnt_q, cnt_d;
  logic [3:0]     cnt4;
  logic           ovf_q, ovf_d;
  logic           full, pop, push_req, push_ok, ovf_set, ovf_clr;
  logic [63:0]    cycle_q, cycle_d;
  logic           halt_w;

  assign full          = (cnt_q == (FAW+1)'(FIFO_DEPTH));
  assign console_valid = (cnt_q != '0);
  assign console_data  = console_valid ? fifo_q[rd_q] : 8'h00;
  assign pop           = console_valid & console_ready;
  assign push_req      = we & io_hit & (io_reg == R_CON) & (byte_en != 4'b0000);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok       = push_req & (~full | pop);
  assign ovf_set       = push_req & full & ~pop;
  assign ovf_clr       = we & io_hit & (io_reg == R_STAT) & byte_en[1] & wdata[8];
  assign cnt4          = 4'(cnt_q);
  assign overflow      = ovf_q;

  always_comb begin
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    cnt_d   = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    cycle_d = halt_w ? cycle_q : cycle_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= 64'd0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

`ifdef TOHOST_EN
  logic        halt_q, halt_d, host_wr;
  logic [31:0] host_q, host_d;

  // First full-word store wins; later ones are ignored until reset.
  assign host_wr = we & io_hit & (io_reg == R_HOST) & (byte_en == 4'b1111) & ~halt_q;

  always_comb begin
    halt_d = halt_q | host_wr;
    host_d = host_wr ? wdata : host_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      halt_q <= 1'b0;
      host_q <= 32'h0;
    end else begin
      halt_q <= halt_d;
      host_q <= host_d;
    end
  end

  assign halt         = halt_q;
  assign tohost_value = host_q;
  assign halt_w       = halt_q;
`else
  assign halt_w = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    if (ram_hit) begin
      rdata = mem[ram_idx];
    end else if (io_hit) begin
      case (io_reg)
        R_STAT:  rdata = {23'b0, ovf_q, 4'b0, cnt4};
        R_CLO:   rdata = cycle_q[31:0];
        R_CHI:   rdata = cycle_q[63:32];
`ifdef TOHOST_EN
        R_HOST:  rdata = host_q;
`endif
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule
